link_tx_sched: RTL and testbench

LINK_TX_SCHED -- requirements
Module: link_tx_sched

---
 rtl/link_tx_sched.sv | 201 ++++++++++++++++++++
 tb/tb_link_tx_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_sched
// Description : Transmit-side symbol scheduler for the 8b10b pulse link.
//               Emits an alignment burst of K28.5 commas after reset, then
//               frames of COMMA_PERIOD slots with a K28.5 in slot 0. Data
//               slots carry 8'h00 (SAFE) or the formatted payload flags
//               (RUN), with a consecutive-RawPls cut-off.
//
//               Data byte : {IsPro, IsMaster, RawPls, p1, Option[2:0], p0}
//                           p1 = ^bits[7:5], p0 = ^Option (even nibbles)
//
// Ports       : i_clk        40 MHz clock
//               i_res        asynchronous active-high reset
//               i_en         pulse transmission enable
//               i_IsPro, i_IsMaster, i_RawPls, i_Option  payload fields
//               i_sym_ready  downstream encoder accepts current symbol
//               o_sym_valid  symbol offered (1 from first clock after reset)
//               o_sym_data   byte to encode
//               o_sym_k      1 = K28.5 control symbol (data = 8'hBC)
//               o_state      0 = ALIGN, 1 = SAFE, 2 = RUN
//               o_pls_fault  RawPls cut-off active
//
// Revision    : 1.0  initial release
// ============================================================================
module link_tx_sched #(
    parameter int COMMA_PERIOD = 256,
    parameter int ALIGN_COMMAS = 4,
    parameter int MAX_ON_SYM   = 64
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_en,
    input  logic       i_IsPro,
    input  logic       i_IsMaster,
    input  logic       i_RawPls,
    input  logic [2:0] i_Option,
    input  logic       i_sym_ready,
    output logic       o_sym_valid,
    output logic [7:0] o_sym_data,
    output logic       o_sym_k,
    output logic [1:0] o_state,
    output logic       o_pls_fault
);

    localparam int                  c_SLOT_W     = $clog2(COMMA_PERIOD);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST  = c_SLOT_W'(COMMA_PERIOD - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE   = c_SLOT_W'(1);
    localparam logic [3:0]          c_ALIGN_LAST = 4'(ALIGN_COMMAS - 1);
    localparam logic [15:0]         c_MAX_ON     = 16'(MAX_ON_SYM);
    localparam logic [7:0]          c_K285       = 8'hBC;

    localparam logic [1:0] c_ST_ALIGN = 2'd0;
    localparam logic [1:0] c_ST_SAFE  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    // Registered state; r_slot is the slot index of the symbol on the output.
    logic [1:0]          r_state;
    logic [c_SLOT_W-1:0] r_slot;
    logic [3:0]          r_align_cnt;
    logic [15:0]         r_on_cnt;
    logic                r_fault;
    logic                r_valid;
    logic [7:0]          r_data;
    logic                r_k;

    // Next-state values
    logic [1:0]          w_state_nx;
    logic [c_SLOT_W-1:0] w_slot_nx;
    logic [3:0]          w_align_nx;
    logic [15:0]         w_on_nx;
    logic                w_fault_nx;
    logic [7:0]          w_data_nx;
    logic                w_k_nx;

    logic                w_xfer;
    logic [c_SLOT_W-1:0] w_slot_inc;
    logic                w_comma_nx;
    logic                w_raw_cut;
    logic                w_raw_tx;
    logic [7:0]          w_payload;

    assign w_xfer     = r_valid & i_sym_ready;
    assign w_slot_inc = (r_slot == c_SLOT_LAST) ? '0 : r_slot + c_SLOT_ONE;
    assign w_comma_nx = (w_slot_inc == '0);

    // The cut-off takes effect on the symbol after the counter has already
    // reached the limit, so exactly MAX_ON_SYM symbols carry RawPls=1.
    assign w_raw_cut  = i_RawPls & (r_on_cnt >= c_MAX_ON);
    assign w_raw_tx   = i_RawPls & ~w_raw_cut;
    assign w_payload  = {i_IsPro, i_IsMaster, w_raw_tx, i_IsPro ^ i_IsMaster ^ w_raw_tx,
                         i_Option, ^i_Option};

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state     <= c_ST_ALIGN;
            r_slot      <= '0;
            r_align_cnt <= 4'd0;
            r_on_cnt    <= 16'd0;
            r_fault     <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= c_K285;
            r_k         <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_slot      <= w_slot_nx;
            r_align_cnt <= w_align_nx;
            r_on_cnt    <= w_on_nx;
            r_fault     <= w_fault_nx;
            r_valid     <= 1'b1;
            r_data      <= w_data_nx;
            r_k         <= w_k_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_align_nx = r_align_cnt;
        w_on_nx    = r_on_cnt;
        w_fault_nx = r_fault;
        w_data_nx  = r_data;
        w_k_nx     = r_k;

        if (w_xfer) begin
            case (r_state)
                c_ST_ALIGN: begin
                    if (r_align_cnt == c_ALIGN_LAST) begin
                        // Last alignment comma doubles as slot 0 of the first frame.
                        w_state_nx = c_ST_SAFE;
                        w_slot_nx  = c_SLOT_ONE;
                        w_align_nx = 4'd0;
                        w_data_nx  = 8'h00;
                        w_k_nx     = 1'b0;
                    end else begin
                        w_align_nx = r_align_cnt + 4'd1;
                        w_data_nx  = c_K285;
                        w_k_nx     = 1'b1;
                    end
                end

                c_ST_SAFE: begin
                    w_slot_nx = w_slot_inc;
                    if (w_comma_nx) begin
                        w_data_nx = c_K285;
                        w_k_nx    = 1'b1;
                        if (i_en) begin
                            w_state_nx = c_ST_RUN;
                        end
                    end else begin
                        w_data_nx = 8'h00;
                        w_k_nx    = 1'b0;
                    end
                end

                c_ST_RUN: begin
                    w_slot_nx = w_slot_inc;
                    if (!i_en) begin
                        // Disable wins over any simultaneous payload change.
                        w_state_nx = c_ST_SAFE;
                        w_on_nx    = 16'd0;
                        w_fault_nx = 1'b0;
                        w_data_nx  = w_comma_nx ? c_K285 : 8'h00;
                        w_k_nx     = w_comma_nx;
                    end else if (w_comma_nx) begin
                        // Comma slots leave the on-counter and fault untouched.
                        w_data_nx = c_K285;
                        w_k_nx    = 1'b1;
                    end else begin
                        w_data_nx  = w_payload;
                        w_k_nx     = 1'b0;
                        w_fault_nx = w_raw_cut;
                        if (i_RawPls) begin
                            w_on_nx = (r_on_cnt == 16'hFFFF) ? r_on_cnt : r_on_cnt + 16'd1;
                        end else begin
                            w_on_nx = 16'd0;
                        end
                    end
                end

                default: begin
                    w_state_nx = c_ST_ALIGN;
                    w_slot_nx  = '0;
                    w_align_nx = 4'd0;
                    w_on_nx    = 16'd0;
                    w_fault_nx = 1'b0;
                    w_data_nx  = c_K285;
                    w_k_nx     = 1'b1;
                end
            endcase
        end
    end

    assign o_sym_valid = r_valid;
    assign o_sym_data  = r_data;
    assign o_sym_k     = r_k;
    assign o_state     = r_state;
    assign o_pls_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_link_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_tx_sched
// Description : Scoreboard bench for link_tx_sched. Stimulus pushes the
//               symbol each transfer will register; a negedge monitor checks
//               the presented symbol against the queue head on every valid
//               cycle and pops it when the symbol is accepted.
//               Payload constants (IsPro=1, IsMaster=0, Option=101):
//                 RawPls=1 -> {1,0,1,0,101,0} = 8'hAA
//                 RawPls=0 -> {1,0,0,1,101,0} = 8'h9A
// Revision    : 1.0  initial release
// ============================================================================
module tb_link_tx_sched;

    localparam int CP = 256;
    localparam logic [1:0] ALIGN = 2'd0;
    localparam logic [1:0] SAFE  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [7:0] ON_B  = 8'hAA;
    localparam logic [7:0] OFF_B = 8'h9A;

    logic       i_clk = 1'b0;
    logic       i_res = 1'b1;
    logic       i_en = 1'b0;
    logic       i_IsPro = 1'b0;
    logic       i_IsMaster = 1'b0;
    logic       i_RawPls = 1'b0;
    logic [2:0] i_Option = 3'b000;
    logic       i_sym_ready = 1'b0;
    logic       o_sym_valid;
    logic [7:0] o_sym_data;
    logic       o_sym_k;
    logic [1:0] o_state;
    logic       o_pls_fault;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic [1:0] st;
        logic       f;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    link_tx_sched #(
        .COMMA_PERIOD(CP),
        .ALIGN_COMMAS(4),
        .MAX_ON_SYM  (3)
    ) dut (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_en       (i_en),
        .i_IsPro    (i_IsPro),
        .i_IsMaster (i_IsMaster),
        .i_RawPls   (i_RawPls),
        .i_Option   (i_Option),
        .i_sym_ready(i_sym_ready),
        .o_sym_valid(o_sym_valid),
        .o_sym_data (o_sym_data),
        .o_sym_k    (o_sym_k),
        .o_state    (o_state),
        .o_pls_fault(o_pls_fault)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: presented symbol must match the queue head on every valid cycle.
    always @(negedge i_clk) begin
        if (!i_res && o_sym_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sym: data=%h k=%b st=%0d f=%b offered with empty scoreboard",
                         o_sym_data, o_sym_k, o_state, o_pls_fault);
            end else begin
                mon_e = q[0];
                if ({o_sym_data, o_sym_k, o_state, o_pls_fault} !== mon_e) begin
                    errors++;
                    $display("FAIL sym @%0t: got data=%h k=%b st=%0d f=%b, exp data=%h k=%b st=%0d f=%b",
                             $time, o_sym_data, o_sym_k, o_state, o_pls_fault,
                             mon_e.d, mon_e.k, mon_e.st, mon_e.f);
                end
                if (i_sym_ready) void'(q.pop_front());
            end
        end
    end

    task automatic chk_out(input string nm, input logic v, input logic [7:0] d,
                           input logic k, input logic [1:0] st, input logic f);
        checks++;
        if ({o_sym_valid, o_sym_data, o_sym_k, o_state, o_pls_fault} !== {v, d, k, st, f}) begin
            errors++;
            $display("FAIL %s: got v=%b data=%h k=%b st=%0d f=%b, exp v=%b data=%h k=%b st=%0d f=%b",
                     nm, o_sym_valid, o_sym_data, o_sym_k, o_state, o_pls_fault, v, d, k, st, f);
        end
    endtask

    // One transfer after 'gap' stalled clocks; pushes the symbol it registers.
    task automatic send(input int gap, input logic en, input logic pro, input logic mas,
                        input logic raw, input logic [2:0] opt, input logic [7:0] ed,
                        input logic ek, input logic [1:0] est, input logic ef);
        exp_t e;
        i_sym_ready = 1'b0;
        repeat (gap) begin
            @(posedge i_clk);
            #2;
        end
        i_en       = en;
        i_IsPro    = pro;
        i_IsMaster = mas;
        i_RawPls   = raw;
        i_Option   = opt;
        e.d  = ed;
        e.k  = ek;
        e.st = est;
        e.f  = ef;
        q.push_back(e);
        i_sym_ready = 1'b1;
        @(posedge i_clk);
        #2;
    endtask

    task automatic s_safe(input int gap, input logic en, input logic raw);
        int nxt;
        nxt = (cur + 1) % CP;
        if (nxt == 0) send(gap, en, 1'b1, 1'b0, raw, 3'b101, 8'hBC, 1'b1, en ? RUN : SAFE, 1'b0);
        else          send(gap, en, 1'b1, 1'b0, raw, 3'b101, 8'h00, 1'b0, SAFE, 1'b0);
        cur = nxt;
    endtask

    task automatic s_run(input int gap, input logic pro, input logic mas, input logic raw,
                         input logic [2:0] opt, input logic [7:0] ed, input logic ef);
        int nxt;
        nxt = (cur + 1) % CP;
        if (nxt == 0) send(gap, 1'b1, pro, mas, raw, opt, 8'hBC, 1'b1, RUN, ef);
        else          send(gap, 1'b1, pro, mas, raw, opt, ed, 1'b0, RUN, ef);
        cur = nxt;
    endtask

    task automatic s_drop(input logic raw);
        int nxt;
        nxt = (cur + 1) % CP;
        if (nxt == 0) send(0, 1'b0, 1'b1, 1'b0, raw, 3'b101, 8'hBC, 1'b1, SAFE, 1'b0);
        else          send(0, 1'b0, 1'b1, 1'b0, raw, 3'b101, 8'h00, 1'b0, SAFE, 1'b0);
        cur = nxt;
    endtask

    task automatic align_seq(input int gap);
        q.push_back('{8'hBC, 1'b1, ALIGN, 1'b0});
        cur = 0;
        @(posedge i_clk);
        #2;
        chk_out("valid_after_release", 1'b1, 8'hBC, 1'b1, ALIGN, 1'b0);
        repeat (3) send(gap, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'hBC, 1'b1, ALIGN, 1'b0);
        send(gap, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, SAFE, 1'b0);
        cur = 1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge i_clk);
        #2;
        chk_out("reset_values", 1'b0, 8'hBC, 1'b1, ALIGN, 1'b0);
        i_res = 1'b0;

        // Alignment burst and one full SAFE frame, ready every 40 clocks
        align_seq(39);
        repeat (254) s_safe(39, 1'b0, 1'b0);        // slots 2..255
        s_safe(39, 1'b0, 1'b0);                     // slot 0 comma, stays SAFE

        // Enable raised mid-frame: no RUN until the next comma
        repeat (50)  s_safe(0, 1'b0, 1'b0);         // slots 1..50
        repeat (205) s_safe(0, 1'b1, 1'b1);         // slots 51..255
        s_safe(0, 1'b1, 1'b1);                      // slot 0 -> RUN

        // RawPls cut-off after three symbols, cleared by RawPls=0
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 1
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 2
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 3
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, OFF_B, 1'b1);   // slot 4 cut
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, OFF_B, 1'b1);   // slot 5 cut
        s_run(0, 1'b1, 1'b0, 1'b0, 3'b101, OFF_B, 1'b0);   // slot 6 clears
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 7
        // Other payload patterns
        s_run(0, 1'b0, 1'b1, 1'b0, 3'b011, 8'h56, 1'b0);   // 0101_0110
        s_run(0, 1'b1, 1'b1, 1'b0, 3'b111, 8'hCF, 1'b0);   // 1100_1111
        s_run(0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0);   // 0000_0000
        s_run(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h33, 1'b0);   // 0011_0011 (slot 11)

        // Alternating pulses with a 500-clock stall at slot 20
        for (int s = 12; s <= 88; s++) begin
            s_run((s == 20) ? 500 : 0, 1'b1, 1'b0, s[0], 3'b101, s[0] ? ON_B : OFF_B, 1'b0);
        end
        for (int s = 89; s <= 99; s++) begin
            s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, (s <= 91) ? ON_B : OFF_B, (s >= 92) ? 1'b1 : 1'b0);
        end
        s_drop(1'b1);                               // slot 100 -> SAFE, fault cleared

        // Back to RUN: on-counter must start from zero; disable beats RawPls rise
        repeat (155) s_safe(0, 1'b0, 1'b0);         // slots 101..255
        s_safe(0, 1'b1, 1'b0);                      // slot 0 -> RUN
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 1
        s_run(0, 1'b1, 1'b0, 1'b0, 3'b101, OFF_B, 1'b0);   // slot 2
        s_drop(1'b1);                                       // slot 3 -> 8'h00

        // Comma slot must not clear the on-counter
        repeat (252) s_safe(0, 1'b0, 1'b0);         // slots 4..255
        s_safe(0, 1'b1, 1'b0);                      // slot 0 -> RUN
        repeat (253) s_run(0, 1'b1, 1'b0, 1'b0, 3'b101, OFF_B, 1'b0);
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 254, on=1
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 255, on=2
        s_run(0, 1'b1, 1'b0, 1'b0, 3'b101, OFF_B, 1'b0);   // slot 0 comma
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, ON_B,  1'b0);   // slot 1, on=3
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, OFF_B, 1'b1);   // slot 2 cut
        s_run(0, 1'b1, 1'b0, 1'b1, 3'b101, OFF_B, 1'b1);   // slot 3 cut
        repeat (34) s_run(0, 1'b1, 1'b0, 1'b0, 3'b101, OFF_B, 1'b0); // slots 4..37

        // Asynchronous reset in the middle of RUN slot 37
        i_sym_ready = 1'b0;
        #5;
        i_res = 1'b1;
        #1;
        chk_out("async_reset", 1'b0, 8'hBC, 1'b1, ALIGN, 1'b0);
        q.delete();
        repeat (3) @(posedge i_clk);
        #2;
        chk_out("reset_held", 1'b0, 8'hBC, 1'b1, ALIGN, 1'b0);
        i_res = 1'b0;
        align_seq(0);
        repeat (5) s_safe(0, 1'b1, 1'b0);

        // Idle, then confirm only the presented symbol remains queued
        i_sym_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #2;
        checks++;
        if (q.size() != 1) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries, exp 1", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
